// File: rtl/game_fsm.sv
// Game controller: menu navigation, per-frame player/obstacle motion, lives,
// box collection and banking. Every output is a register updated on clk.
module game_fsm #(
  parameter logic [9:0] BOX_WIDTH       = 10'd30,
  parameter logic [9:0] BOX_BASE_HEIGHT = 10'd30,
  parameter logic [9:0] PLAYER_X_RESET  = 10'd300,
  parameter logic [9:0] PLAYER_SPEED    = 10'd4,
  parameter logic [9:0] OBS_SPEED       = 10'd3,
  parameter logic [2:0] MAX_HELD        = 3'd7,
  parameter logic [7:0] INVULN_FRAMES   = 8'd60,
  parameter logic [7:0] RESPAWN_FRAMES  = 8'd90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_select,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       hit_obstacle,
  input  logic       touch_green,
  input  logic       at_bank,
  output logic [1:0] game_state,
  output logic       menu_selection,
  output logic [1:0] current_hp,
  output logic [7:0] bank_level,
  output logic [9:0] player_x,
  output logic [9:0] player_height,
  output logic [9:0] obstacle_x,
  output logic       green_active
);

  typedef enum logic [1:0] {
    ST_START   = 2'b00,
    ST_PLAYING = 2'b01,
    ST_INSTR   = 2'b10,
    ST_OVER    = 2'b11
  } state_t;

  localparam logic [9:0] SCREEN_W = 10'd640;
  localparam logic [9:0] X_MAX    = SCREEN_W - BOX_WIDTH;

  state_t      state_q, state_d;
  logic        menu_q, menu_d;
  logic [1:0]  hp_q, hp_d;
  logic [7:0]  bank_q, bank_d;
  logic [2:0]  held_q, held_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  ox_q, ox_d;
  logic [9:0]  height_q, height_d;
  logic        green_q, green_d;
  logic [7:0]  invuln_q, invuln_d;
  logic [7:0]  respawn_q, respawn_d;

  logic        hit_taken;
  logic [8:0]  bank_sum;
  logic [10:0] px_right;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_START;
      menu_q    <= 1'b0;
      hp_q      <= 2'd3;
      bank_q    <= 8'd0;
      held_q    <= 3'd0;
      px_q      <= PLAYER_X_RESET;
      ox_q      <= SCREEN_W;
      height_q  <= BOX_BASE_HEIGHT;
      green_q   <= 1'b1;
      invuln_q  <= 8'd0;
      respawn_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      menu_q    <= menu_d;
      hp_q      <= hp_d;
      bank_q    <= bank_d;
      held_q    <= held_d;
      px_q      <= px_d;
      ox_q      <= ox_d;
      height_q  <= height_d;
      green_q   <= green_d;
      invuln_q  <= invuln_d;
      respawn_q <= respawn_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    menu_d    = menu_q;
    hp_d      = hp_q;
    bank_d    = bank_q;
    held_d    = held_q;
    px_d      = px_q;
    ox_d      = ox_q;
    green_d   = green_q;
    invuln_d  = invuln_q;
    respawn_d = respawn_q;
    hit_taken = hit_obstacle && (invuln_q == 8'd0);
    bank_sum  = {1'b0, bank_q} + {6'd0, held_q};
    px_right  = {1'b0, px_q} + {1'b0, PLAYER_SPEED};

    case (state_q)
      ST_START: begin
        if (btn_select) begin
          if (!menu_q) begin
            state_d   = ST_PLAYING;
            hp_d      = 2'd3;
            bank_d    = 8'd0;
            held_d    = 3'd0;
            px_d      = PLAYER_X_RESET;
            ox_d      = SCREEN_W;
            green_d   = 1'b1;
            invuln_d  = 8'd0;
            respawn_d = 8'd0;
          end else begin
            state_d = ST_INSTR;
          end
        end else if (btn_up ^ btn_down) begin
          menu_d = ~menu_q;
        end
      end

      ST_INSTR: begin
        if (btn_select) state_d = ST_START;
      end

      ST_OVER: begin
        if (btn_select) begin
          state_d = ST_START;
          menu_d  = 1'b0;
        end
      end

      ST_PLAYING: begin
        if (frame_tick) begin
          if (btn_left && !btn_right) begin
            px_d = (px_q < PLAYER_SPEED) ? 10'd0 : px_q - PLAYER_SPEED;
          end else if (btn_right && !btn_left) begin
            px_d = (px_right > {1'b0, X_MAX}) ? X_MAX : px_right[9:0];
          end

          ox_d = (ox_q < OBS_SPEED) ? SCREEN_W : ox_q - OBS_SPEED;

          if (invuln_q != 8'd0) invuln_d = invuln_q - 8'd1;
          if (respawn_q != 8'd0) begin
            respawn_d = respawn_q - 8'd1;
            if (respawn_q == 8'd1) green_d = 1'b1;
          end

          // Hit outranks deposit, which outranks collect, within one frame.
          if (hit_taken) begin
            held_d   = 3'd0;
            invuln_d = INVULN_FRAMES;
            if (hp_q <= 2'd1) begin
              hp_d    = 2'd0;
              state_d = ST_OVER;
            end else begin
              hp_d = hp_q - 2'd1;
            end
          end else if (at_bank && (held_q != 3'd0)) begin
            bank_d = bank_sum[8] ? 8'hFF : bank_sum[7:0];
            held_d = 3'd0;
          end else if (touch_green && green_q && (held_q < MAX_HELD)) begin
            held_d    = held_q + 3'd1;
            green_d   = 1'b0;
            respawn_d = RESPAWN_FRAMES;
          end
        end
      end

      default: state_d = ST_START;
    endcase

    height_d = BOX_BASE_HEIGHT + ({7'd0, held_d} * BOX_WIDTH);
  end

  assign game_state     = state_q;
  assign menu_selection = menu_q;
  assign current_hp     = hp_q;
  assign bank_level     = bank_q;
  assign player_x       = px_q;
  assign player_height  = height_q;
  assign obstacle_x     = ox_q;
  assign green_active   = green_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm: a vector table for menu and single-frame
// behaviour, then hand-written multi-frame sequences for timers and limits.
module tb_game_fsm;

  logic       clk;
  logic       rst;
  logic       frame_tick;
  logic       btn_up, btn_down, btn_select, btn_left, btn_right;
  logic       hit_obstacle, touch_green, at_bank;
  logic [1:0] game_state;
  logic       menu_selection;
  logic [1:0] current_hp;
  logic [7:0] bank_level;
  logic [9:0] player_x, player_height, obstacle_x;
  logic       green_active;

  int n_pass = 0;
  int n_total = 0;
  logic [9:0] exp_ox;

  game_fsm dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .btn_select     (btn_select),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .hit_obstacle   (hit_obstacle),
    .touch_green    (touch_green),
    .at_bank        (at_bank),
    .game_state     (game_state),
    .menu_selection (menu_selection),
    .current_hp     (current_hp),
    .bank_level     (bank_level),
    .player_x       (player_x),
    .player_height  (player_height),
    .obstacle_x     (obstacle_x),
    .green_active   (green_active)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, t, u, d, s, l, rt, h, g, b;
    logic [1:0] st;
    logic       m;
    logic [1:0] hp;
    logic [7:0] bl;
    logic [9:0] px, ox, ph;
    logic       ga;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, t, u, d, s, l, rt, h, g, b,
                     input logic [1:0] st, input logic m, input logic [1:0] hp,
                     input logic [7:0] bl, input logic [9:0] px, ox, ph,
                     input logic ga);
    vec_t v;
    v.r = r; v.t = t; v.u = u; v.d = d; v.s = s; v.l = l; v.rt = rt;
    v.h = h; v.g = g; v.b = b;
    v.st = st; v.m = m; v.hp = hp; v.bl = bl; v.px = px; v.ox = ox;
    v.ph = ph; v.ga = ga;
    vq.push_back(v);
  endtask

  // driver: inputs applied at a falling edge, outputs read at the next one
  task automatic cyc(input logic r, t, u, d, s, l, rt, h, g, b);
    rst = r; frame_tick = t; btn_up = u; btn_down = d; btn_select = s;
    btn_left = l; btn_right = rt; hit_obstacle = h; touch_green = g; at_bank = b;
    @(negedge clk);
    rst = 0; frame_tick = 0; btn_up = 0; btn_down = 0; btn_select = 0;
    btn_left = 0; btn_right = 0; hit_obstacle = 0; touch_green = 0; at_bank = 0;
  endtask

  task automatic frame(input logic l, rt, h, g, b);
    cyc(0, 1, 0, 0, 0, l, rt, h, g, b);
  endtask

  task automatic idle_frames(input int n);
    for (int i = 0; i < n; i++) frame(0, 0, 0, 0, 0);
  endtask

  task automatic start_game();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  // scoreboard
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // movement frame that also tracks the obstacle and checks it near the wrap
  task automatic mframe(input logic l, rt);
    logic [9:0] prev;
    prev = exp_ox;
    exp_ox = (prev < 10'd3) ? 10'd640 : prev - 10'd3;
    frame(l, rt, 0, 0, 0);
    if (prev < 10'd3 || prev == 10'd4) chk("obstacle_wrap", obstacle_x, exp_ox);
  endtask

  task automatic collect_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame(0, 0, 0, 1, 0);
      idle_frames(90);
    end
  endtask

  initial begin
    rst = 1; frame_tick = 0; btn_up = 0; btn_down = 0; btn_select = 0;
    btn_left = 0; btn_right = 0; hit_obstacle = 0; touch_green = 0; at_bank = 0;
    @(negedge clk);

    //   r t u d s l rt h g b   st m hp bl  px   ox   ph  ga
    add(1,0,0,0,0,0,0,0,0,0,  0,0,3,0, 300,640, 30,1);
    add(0,0,0,1,0,0,0,0,0,0,  0,1,3,0, 300,640, 30,1);
    add(0,0,1,0,0,0,0,0,0,0,  0,0,3,0, 300,640, 30,1);
    add(0,0,1,1,0,0,0,0,0,0,  0,0,3,0, 300,640, 30,1);
    add(0,0,0,1,0,0,0,0,0,0,  0,1,3,0, 300,640, 30,1);
    add(0,0,0,0,1,0,0,0,0,0,  2,1,3,0, 300,640, 30,1);
    add(0,0,1,0,0,0,0,0,0,0,  2,1,3,0, 300,640, 30,1);
    add(0,1,0,0,0,1,0,1,1,1,  2,1,3,0, 300,640, 30,1);
    add(0,0,0,0,1,0,0,0,0,0,  0,1,3,0, 300,640, 30,1);
    add(0,0,1,0,0,0,0,0,0,0,  0,0,3,0, 300,640, 30,1);
    add(0,0,0,0,1,0,0,0,0,0,  1,0,3,0, 300,640, 30,1);
    add(0,1,0,0,0,0,1,0,0,0,  1,0,3,0, 304,637, 30,1);
    add(0,0,0,0,0,0,1,0,0,0,  1,0,3,0, 304,637, 30,1);
    add(0,1,0,0,0,1,1,0,0,0,  1,0,3,0, 304,634, 30,1);
    add(0,1,0,0,0,1,0,0,0,0,  1,0,3,0, 300,631, 30,1);
    add(0,1,0,0,0,0,0,0,1,0,  1,0,3,0, 300,628, 60,0);
    add(0,1,0,0,0,0,0,0,0,1,  1,0,3,1, 300,625, 30,0);
    add(0,0,1,1,1,0,0,0,0,0,  1,0,3,1, 300,625, 30,0);
    add(0,1,0,0,0,0,0,1,0,0,  1,0,2,1, 300,622, 30,0);
    add(0,1,0,0,0,0,0,1,0,0,  1,0,2,1, 300,619, 30,0);
    add(1,1,1,0,1,1,0,1,1,1,  0,0,3,0, 300,640, 30,1);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].r, vq[i].t, vq[i].u, vq[i].d, vq[i].s, vq[i].l, vq[i].rt,
          vq[i].h, vq[i].g, vq[i].b);
      n_total++;
      if ({game_state, menu_selection, current_hp, bank_level, player_x, obstacle_x,
           player_height, green_active} ===
          {vq[i].st, vq[i].m, vq[i].hp, vq[i].bl, vq[i].px, vq[i].ox, vq[i].ph, vq[i].ga})
        n_pass++;
      else
        $display("FAIL vec%0d: got st=%0d m=%0d hp=%0d bl=%0d px=%0d ox=%0d ph=%0d ga=%0d expected st=%0d m=%0d hp=%0d bl=%0d px=%0d ox=%0d ph=%0d ga=%0d",
                 i, game_state, menu_selection, current_hp, bank_level, player_x, obstacle_x,
                 player_height, green_active, vq[i].st, vq[i].m, vq[i].hp, vq[i].bl,
                 vq[i].px, vq[i].ox, vq[i].ph, vq[i].ga);
    end

    // collect three boxes with respawn gaps, then bank them
    start_game();
    frame(0, 0, 0, 1, 0);
    chk("collect1_height", player_height, 60);
    chk("collect1_green", green_active, 0);
    idle_frames(89);
    chk("respawn_not_yet", green_active, 0);
    idle_frames(1);
    chk("respawn_done", green_active, 1);
    frame(0, 0, 0, 1, 0);
    chk("collect2_height", player_height, 90);
    idle_frames(90);
    frame(0, 0, 0, 1, 0);
    chk("collect3_height", player_height, 120);
    frame(0, 0, 0, 0, 1);
    chk("deposit3_bank", bank_level, 3);
    chk("deposit3_height", player_height, 30);

    // invulnerability window, then the fatal frame with all three flags
    start_game();
    frame(0, 0, 1, 0, 0);
    chk("first_hit_hp", current_hp, 2);
    for (int k = 1; k <= 59; k++) begin
      frame(0, 0, 1, 0, 0);
      chk("invuln_hp", current_hp, 2);
    end
    idle_frames(1);
    frame(0, 0, 1, 0, 0);
    chk("post_invuln_hit_hp", current_hp, 1);
    frame(0, 0, 0, 1, 0);
    chk("held_before_death", player_height, 60);
    idle_frames(90);
    chk("green_before_death", green_active, 1);
    frame(0, 0, 1, 1, 1);
    chk("death_state", game_state, 3);
    chk("death_hp", current_hp, 0);
    chk("death_height", player_height, 30);
    chk("death_bank", bank_level, 0);
    chk("death_green", green_active, 1);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("over_to_start_state", game_state, 0);
    chk("over_to_start_menu", menu_selection, 0);

    // movement clamps, obstacle reload, hold cap and bank saturation
    start_game();
    exp_ox = 10'd640;
    for (int i = 0; i < 78; i++) mframe(0, 1);
    chk("right_clamp", player_x, 610);
    for (int i = 0; i < 152; i++) mframe(1, 0);
    chk("x_at_2", player_x, 2);
    mframe(1, 0);
    chk("left_clamp", player_x, 0);
    mframe(1, 0);
    chk("left_clamp_hold", player_x, 0);
    for (int grp = 0; grp < 35; grp++) begin
      collect_n(7);
      frame(0, 0, 0, 0, 1);
    end
    collect_n(5);
    frame(0, 0, 0, 0, 1);
    chk("bank_250", bank_level, 250);
    collect_n(7);
    chk("max_height", player_height, 240);
    chk("max_green", green_active, 1);
    frame(0, 0, 0, 1, 0);
    chk("cap_ignore_height", player_height, 240);
    chk("cap_ignore_green", green_active, 1);
    frame(0, 0, 0, 0, 1);
    chk("bank_saturate", bank_level, 255);
    chk("bank_sat_height", player_height, 30);

    // final bank survives game over and clears on the next start
    frame(0, 0, 1, 0, 0);
    idle_frames(60);
    frame(0, 0, 1, 0, 0);
    idle_frames(60);
    frame(0, 0, 1, 0, 0);
    chk("gameover2_state", game_state, 3);
    chk("gameover2_bank", bank_level, 255);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("start_bank_hold", bank_level, 255);
    cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    chk("restart_state", game_state, 1);
    chk("restart_bank", bank_level, 0);
    chk("restart_hp", current_hp, 3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
